rns_crt_reconstruct: RTL and testbench

- Multi-cycle reverse converter. Takes a two-domain residue word produced by the EX stage's RNS ALU or RLLM path and rebuilds the 16-bit integer it represents.
- Uses mixed-radix CRT with moduli 256 and 129; the dynamic range M is 33024.
- Sits beside the MEM/WB path. The RNS regfile read port supplies the residues, and the result is written back to an integer register pair tagged by dest_tag.
- Uses a serial shift-add modular multiply, so no DSP is inferred.

---
 rtl/rns_crt_reconstruct_pkg.sv | 13 +
 rtl/rns_crt_reconstruct_mod_dbl_add.sv | 16 +
 rtl/rns_crt_reconstruct.sv | 89 ++++++++
 tb/tb_rns_crt_reconstruct.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rns_crt_reconstruct_pkg.sv
// rns_crt_reconstruct_pkg: moduli, constants, FSM states and rns_in field layout for the CRT reverse converter
package rns_crt_reconstruct_pkg;
  localparam logic [8:0]  M_HI       = 9'd256;
  localparam logic [7:0]  M_LO       = 8'd129;
  localparam logic [7:0]  INV        = 8'd64;
  localparam int          INV_BITS   = 8;
  localparam logic [15:0] HALF_RANGE = 16'd16512;
  localparam int          HI_MSB     = 15;
  localparam int          HI_LSB     = 8;
  localparam int          LO_MSB     = 7;
  localparam int          LO_LSB     = 0;
  typedef enum logic [2:0] {IDLE, SUB, MUL, COMB, DONE} state_t;
endpackage

// File: rtl/rns_crt_reconstruct_mod_dbl_add.sv
// mod_dbl_add: combinational (2*acc + addend) mod modulus, valid while acc and addend are below modulus
module mod_dbl_add (
  input  logic [7:0] acc,
  input  logic [7:0] addend,
  input  logic [7:0] modulus,
  output logic [7:0] sum
);
  logic [9:0] t, t1, t2, m;
  always_comb begin
    m   = {2'b00, modulus};
    t   = {1'b0, acc, 1'b0} + {2'b00, addend};
    t1  = t >= m ? t - m : t;
    t2  = t1 >= m ? t1 - m : t1;
    sum = t2[7:0];
  end
endmodule

// File: rtl/rns_crt_reconstruct.sv
// rns_crt_reconstruct: serial mixed-radix CRT converter, {r_hi mod 256, r_lo mod 129} -> 16-bit integer
module rns_crt_reconstruct
  import rns_crt_reconstruct_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rns_in,
  input  logic [3:0]  dest_tag_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] int_result,
  output logic        result_neg,
  output logic        range_err,
  output logic [3:0]  dest_tag_out
);
  state_t     state, nstate;
  logic [7:0] r_hi, r_lo, diff, acc, a, diff_n, step;
  logic [3:0] tag;
  logic [2:0] cnt;
  logic       range_err_q;
  logic [15:0] x;

  mod_dbl_add u_step (
    .acc    (acc),
    .addend (INV[cnt] ? diff : 8'd0),
    .modulus(M_LO),
    .sum    (step)
  );

  always_comb begin
    a      = r_hi >= M_LO ? r_hi - M_LO : r_hi;
    diff_n = range_err_q ? 8'd0 : (r_lo >= a ? r_lo - a : r_lo + M_LO - a);
    x      = {acc, r_hi};
    nstate = state;
    case (state)
      IDLE:    nstate = start ? SUB : IDLE;
      SUB:     nstate = MUL;
      MUL:     nstate = cnt == 3'd0 ? COMB : MUL;
      COMB:    nstate = DONE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      int_result   <= '0;
      result_neg   <= 1'b0;
      range_err    <= 1'b0;
      dest_tag_out <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      tag          <= '0;
      range_err_q  <= 1'b0;
      diff         <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else begin
      state <= nstate;
      busy  <= nstate != IDLE;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        r_hi        <= rns_in[HI_MSB:HI_LSB];
        r_lo        <= rns_in[LO_MSB:LO_LSB];
        tag         <= dest_tag_in;
        range_err_q <= rns_in[LO_MSB:LO_LSB] >= M_LO;
      end
      if (state == SUB) begin
        diff <= diff_n;
        acc  <= '0;
        cnt  <= 3'(INV_BITS - 1);
      end
      if (state == MUL) begin
        acc <= step;
        cnt <= cnt - 3'd1;
      end
      // acc < M_LO fits 8 bits, and M_HI = 256 makes the recombination a concatenation
      if (state == COMB) begin
        int_result   <= range_err_q ? 16'd0 : x;
        result_neg   <= !range_err_q && x >= HALF_RANGE;
        range_err    <= range_err_q;
        dest_tag_out <= tag;
      end
    end
  end
endmodule

// File: tb/tb_rns_crt_reconstruct.sv
// tb_rns_crt_reconstruct: scoreboard bench for the CRT reverse converter
module tb_rns_crt_reconstruct;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rns_in = '0;
  logic [3:0]  dest_tag_in = '0;
  logic        busy, done, result_neg, range_err;
  logic [15:0] int_result;
  logic [3:0]  dest_tag_out;

  typedef struct {
    logic [15:0] x;
    logic        neg;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  rns_crt_reconstruct dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rns_in      (rns_in),
    .dest_tag_in (dest_tag_in),
    .busy        (busy),
    .done        (done),
    .int_result  (int_result),
    .result_neg  (result_neg),
    .range_err   (range_err),
    .dest_tag_out(dest_tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] tag);
    exp_t e;
    e.x = 16'd0;
    e.tag = tag;
    e.err = lo >= 8'd129;
    if (!e.err)
      for (int v = 0; v < 33024; v++)
        if (v % 256 == int'(hi) && v % 129 == int'(lo)) e.x = 16'(v);
    e.neg = !e.err && e.x >= 16'd16512;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      n_done++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("int_result", 32'(int_result), 32'(e.x));
        check("result_neg", 32'(result_neg), 32'(e.neg));
        check("range_err", 32'(range_err), 32'(e.err));
        check("dest_tag", 32'(dest_tag_out), 32'(e.tag));
      end
    end
  end

  task automatic convert(input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] tag, input bit interfere);
    exp_t e;
    int lat;
    int d0;
    e = model(hi, lo, tag);
    @(negedge clk);
    rns_in = {hi, lo};
    dest_tag_in = tag;
    start = 1'b1;
    sb.push_back(e);
    d0 = n_done;
    @(posedge clk);
    #1 start = 1'b0;
    rns_in = 16'($urandom);
    dest_tag_in = 4'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_running", 32'(busy), 32'd1);
      if (interfere && (i == 3 || i == 7)) begin
        start = 1'b1;
        rns_in = {8'd17, 8'd3};
        dest_tag_in = 4'b0010;
      end else start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd12);
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hold_result", 32'(int_result), 32'(e.x));
    if (interfere) begin
      repeat (15) @(negedge clk);
      check("single_done", 32'(n_done - d0), 32'd1);
    end
  endtask

  initial begin
    int d0;
    logic [15:0] x;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(int_result), 32'd0);
    check("rst_tag", 32'(dest_tag_out), 32'd0);
    reset = 1'b1;
    convert(8'd5, 8'd5, 4'h1, 1'b0);
    convert(8'd232, 8'd97, 4'h2, 1'b0);
    convert(8'd255, 8'd128, 4'h3, 1'b0);
    convert(8'd0, 8'd200, 4'h4, 1'b0);
    convert(8'd127, 8'd128, 4'h5, 1'b0);
    convert(8'd128, 8'd0, 4'h6, 1'b0);
    convert(8'd0, 8'd0, 4'h7, 1'b0);
    convert(8'd232, 8'd97, 4'b1011, 1'b1);
    for (int k = 0; k < 6; k++) begin
      x = 16'($urandom_range(0, 33023));
      convert(8'(x % 16'd256), 8'(x % 16'd129), 4'(k), 1'b0);
    end
    // abort mid-multiply: nothing may be emitted
    @(negedge clk);
    rns_in = {8'd9, 8'd9};
    start = 1'b1;
    d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(int_result), 32'd0);
    check("abort_neg", 32'(result_neg), 32'd0);
    check("abort_err", 32'(range_err), 32'd0);
    check("abort_tag", 32'(dest_tag_out), 32'd0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    convert(8'd232, 8'd97, 4'h9, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
